sqw_div_sequencer: RTL

- Converts a requested square-wave frequency (Hz) and duty cycle (%) into the two clock-count words the waveform counter consumes: period and high time.
- Owns and sequences one shared 32-bit combinational divider, which is instantiated outside this block.
- Presents operands to the divider, holds them for a fixed multicycle window, then samples quotient and remainder.
- Sits between the frequency/duty control registers and the waveform counter.

---
 rtl/sqw_div_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sqw_div_sequencer.sv
// Turns a frequency/duty request into period and high-time clock counts by
// sequencing three passes through a shared external multicycle divider.
module sqw_div_sequencer #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned DIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] freq,
    input  logic [6:0]  duty,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] period,
    output logic [31:0] high_cnt,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV1,
        S_DIV2,
        S_DIV3,
        S_DONE
    } state_t;

    localparam logic [3:0]  WAIT_LAST = 4'(DIV_WAIT - 1);
    localparam logic [31:0] CLK_WORD  = 32'(CLK_HZ);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] f_reg, f_next;
    logic [6:0]  d_reg, d_next;
    logic [31:0] p_reg, p_next;
    logic [31:0] pq_reg, pq_next;
    logic [31:0] pr_reg, pr_next;
    logic [31:0] period_reg, period_next;
    logic [31:0] high_reg, high_next;
    logic        err_reg, err_next;
    logic        wait_last;
    logic [31:0] d_word;

    assign wait_last = (cnt_reg == WAIT_LAST);
    assign d_word    = {25'd0, d_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            f_reg      <= '0;
            d_reg      <= '0;
            p_reg      <= '0;
            pq_reg     <= '0;
            pr_reg     <= '0;
            period_reg <= '0;
            high_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            f_reg      <= f_next;
            d_reg      <= d_next;
            p_reg      <= p_next;
            pq_reg     <= pq_next;
            pr_reg     <= pr_next;
            period_reg <= period_next;
            high_reg   <= high_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = '0;
        f_next      = f_reg;
        d_next      = d_reg;
        p_next      = p_reg;
        pq_next     = pq_reg;
        pr_next     = pr_reg;
        period_next = period_reg;
        high_next   = high_reg;
        err_next    = err_reg;
        div_a       = '0;
        div_b       = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    f_next = freq;
                    d_next = (duty > 7'd100) ? 7'd100 : duty;
                    if (freq == 32'd0) begin
                        state_next  = S_DONE;
                        period_next = '0;
                        high_next   = '0;
                        err_next    = 1'b1;
                    end else begin
                        state_next = S_DIV1;
                    end
                end
            end
            S_DIV1: begin
                div_a = CLK_WORD;
                div_b = f_reg;
                if (wait_last) begin
                    p_next = div_q;
                    if (div_q == 32'd0) begin
                        state_next  = S_DONE;
                        period_next = '0;
                        high_next   = '0;
                        err_next    = 1'b1;
                    end else begin
                        state_next = S_DIV2;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DIV2: begin
                div_a = p_reg;
                div_b = 32'd100;
                if (wait_last) begin
                    pq_next    = div_q;
                    pr_next    = div_r;
                    state_next = S_DIV3;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DIV3: begin
                // Split p*d/100 as (p/100)*d + ((p%100)*d)/100 so nothing overflows 32 bits.
                div_a = pr_reg * d_word;
                div_b = 32'd100;
                if (wait_last) begin
                    period_next = p_reg;
                    high_next   = pq_reg * d_word + div_q;
                    err_next    = 1'b0;
                    state_next  = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == S_DIV1) || (state_reg == S_DIV2) || (state_reg == S_DIV3);
    assign done     = (state_reg == S_DONE);
    assign err      = err_reg;
    assign period   = period_reg;
    assign high_cnt = high_reg;

endmodule
